hwjsoc_cpu_dct_packer: RTL and testbench

- Transmit-side producer of the CPU debug compressed-trace (DCT) stream consumed by the OCI test bench (dct_buffer / dct_count).
- Accepts 2-bit trace codes from the CPU trace tap and packs up to 15 of them into a 30-bit frame with a 4-bit fill count.
- Hands completed or flushed frames out through a single-entry valid/ready holding register.
- Exposes the live accumulator as dct_buffer / dct_count for the OCI bench.

---
 rtl/hwjsoc_dct_pkg.sv | 21 ++
 rtl/hwjsoc_dct_out_slot.sv | 55 +++++
 rtl/hwjsoc_cpu_dct_packer.sv | 121 ++++++++++++
 tb/tb_hwjsoc_cpu_dct_packer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/hwjsoc_dct_pkg.sv
// Shared constants and types for the CPU debug compressed-trace (DCT) stream.
package hwjsoc_dct_pkg;

  localparam int DCT_CODE_W = 2;
  localparam int DCT_DEPTH  = 15;
  localparam int DCT_BUF_W  = 30;
  localparam int DCT_CNT_W  = 4;

  typedef enum logic [DCT_CODE_W-1:0] {
    DCT_NOP       = 2'd0,
    DCT_TAKEN     = 2'd1,
    DCT_NOT_TAKEN = 2'd2,
    DCT_RESYNC    = 2'd3
  } dct_code_e;

  typedef enum logic {
    DCT_ACCUM = 1'b0,
    DCT_STALL = 1'b1
  } dct_acc_state_e;

endpackage

// File: rtl/hwjsoc_dct_out_slot.sv
// Single-entry valid/ready holding register; a load is allowed whenever the
// slot is empty or being drained in the same cycle (pass-through drain).
module hwjsoc_dct_out_slot #(
  parameter int BUF_W = 30,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [BUF_W-1:0] load_data,
  input  logic [CNT_W-1:0] load_count,
  input  logic             out_ready,
  output logic             slot_free,
  output logic             out_valid,
  output logic [BUF_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count
);

  logic             valid_q, valid_d;
  logic [BUF_W-1:0] data_q,  data_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign slot_free = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    if (load && slot_free) begin
      valid_d = 1'b1;
      data_d  = load_data;
      count_d = load_count;
    end else if (out_ready) begin
      // data/count keep their last value after a drain
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_count = count_q;

endmodule

// File: rtl/hwjsoc_cpu_dct_packer.sv
// Packs 2-bit trace codes into 15-code frames (oldest code highest) and hands
// full or flushed frames to a single-entry output slot; drops codes when full and blocked.
module hwjsoc_cpu_dct_packer
  import hwjsoc_dct_pkg::*;
#(
  parameter int CODE_W = DCT_CODE_W,
  parameter int DEPTH  = DCT_DEPTH,
  parameter int BUF_W  = DCT_BUF_W,
  parameter int CNT_W  = DCT_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [CODE_W-1:0] code,
  input  logic              code_valid,
  input  logic              flush,
  input  logic              test_ending,
  input  logic              frame_ready,
  output logic              frame_valid,
  output logic [BUF_W-1:0]  frame_data,
  output logic [CNT_W-1:0]  frame_count,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              overflow,
  output logic [7:0]        drop_count
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  dct_acc_state_e   state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_flush_q, pend_flush_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_q, drop_d;

  logic             slot_free;
  logic             accept, drop, carry, launch, flush_req;
  logic [BUF_W-1:0] nxt_buf;
  logic [CNT_W-1:0] nxt_cnt;

  always_comb begin
    accept    = code_valid && (state_q == DCT_ACCUM);
    drop      = code_valid && (state_q == DCT_STALL) && !slot_free;
    // A code arriving while full and the slot frees opens the next frame.
    carry     = code_valid && (state_q == DCT_STALL) && slot_free;
    nxt_buf   = accept ? {buf_q[BUF_W-CODE_W-1:0], code} : buf_q;
    nxt_cnt   = accept ? cnt_q + 1'b1 : cnt_q;
    flush_req = flush || test_ending || pend_flush_q;
    launch    = slot_free && ((nxt_cnt == FULL) || (flush_req && nxt_cnt != '0));

    state_d      = DCT_ACCUM;
    buf_d        = nxt_buf;
    cnt_d        = nxt_cnt;
    pend_flush_d = pend_flush_q || (flush && nxt_cnt != '0);
    overflow_d   = overflow_q || drop;
    drop_d       = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

    if (launch) begin
      pend_flush_d = 1'b0;
      if (carry) begin
        buf_d = BUF_W'(code);
        cnt_d = CNT_W'(1);
      end else begin
        buf_d = '0;
        cnt_d = '0;
      end
    end else if (nxt_cnt == FULL) begin
      state_d = DCT_STALL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= DCT_ACCUM;
      buf_q        <= '0;
      cnt_q        <= '0;
      pend_flush_q <= 1'b0;
      overflow_q   <= 1'b0;
      drop_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      pend_flush_q <= pend_flush_d;
      overflow_q   <= overflow_d;
      drop_q       <= drop_d;
    end
  end

  hwjsoc_dct_out_slot #(
    .BUF_W (BUF_W),
    .CNT_W (CNT_W)
  ) u_out_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (launch),
    .load_data  (nxt_buf),
    .load_count (nxt_cnt),
    .out_ready  (frame_ready),
    .slot_free  (slot_free),
    .out_valid  (frame_valid),
    .out_data   (frame_data),
    .out_count  (frame_count)
  );

  assign dct_buffer = buf_q;
  assign dct_count  = cnt_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_hwjsoc_cpu_dct_packer.sv
// Directed bench for the DCT packer: full frames, flush, stall/drop, no-bubble reload, async reset.
module tb_hwjsoc_cpu_dct_packer;
  import hwjsoc_dct_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  code;
  logic        code_valid, flush, test_ending, frame_ready;
  logic        frame_valid, overflow;
  logic [29:0] frame_data, dct_buffer;
  logic [3:0]  frame_count, dct_count;
  logic [7:0]  drop_count;

  int errors = 0;
  int checks = 0;

  hwjsoc_cpu_dct_packer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .code        (code),
    .code_valid  (code_valid),
    .flush       (flush),
    .test_ending (test_ending),
    .frame_ready (frame_ready),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .frame_count (frame_count),
    .dct_buffer  (dct_buffer),
    .dct_count   (dct_count),
    .overflow    (overflow),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] c, input int n);
    code       = c;
    code_valid = 1'b1;
    for (int k = 0; k < n; k++) tick();
    code_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; code = '0; code_valid = 0; flush = 0; test_ending = 0; frame_ready = 1;
    tick(); tick();
    chk("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
    chk("rst_frame_data",  {2'd0, frame_data},  32'd0);
    chk("rst_frame_count", {28'd0, frame_count}, 32'd0);
    chk("rst_dct_buffer",  {2'd0, dct_buffer},  32'd0);
    chk("rst_dct_count",   {28'd0, dct_count},  32'd0);
    chk("rst_overflow",    {31'd0, overflow},   32'd0);
    chk("rst_drop_count",  {24'd0, drop_count}, 32'd0);
    reset_n = 1'b1;
    tick(); tick(); tick();

    // 15 codes 1,2,3,0,... back to back
    code_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      code = 2'((i + 1) % 4);
      tick();
      if (i == 13) begin
        chk("t1_cnt14",   {28'd0, dct_count}, 32'd14);
        chk("t1_valid14", {31'd0, frame_valid}, 32'd0);
      end
    end
    code_valid = 1'b0;
    chk("t1_valid",   {31'd0, frame_valid}, 32'd1);
    chk("t1_count",   {28'd0, frame_count}, 32'd15);
    chk("t1_data",    {2'd0, frame_data},   32'h1B1B1B1B);
    chk("t1_dct_cnt", {28'd0, dct_count},   32'd0);
    tick();
    chk("t1_drained", {31'd0, frame_valid}, 32'd0);
    chk("t1_hold",    {2'd0, frame_data},   32'h1B1B1B1B);

    // 3 codes then flush
    send(DCT_RESYNC, 1); send(DCT_TAKEN, 1); send(DCT_NOT_TAKEN, 1);
    chk("t2_buf", {2'd0, dct_buffer}, 32'h36);
    chk("t2_cnt", {28'd0, dct_count}, 32'd3);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t2_valid",   {31'd0, frame_valid}, 32'd1);
    chk("t2_count",   {28'd0, frame_count}, 32'd3);
    chk("t2_data",    {2'd0, frame_data},   32'h36);
    chk("t2_dct_cnt", {28'd0, dct_count},   32'd0);
    chk("t2_dct_buf", {2'd0, dct_buffer},   32'd0);
    tick();

    // blocked downstream: 15 + 15 + 10 dropped
    frame_ready = 1'b0;
    send(DCT_NOT_TAKEN, 15);
    chk("t3_f1_valid", {31'd0, frame_valid}, 32'd1);
    chk("t3_f1_data",  {2'd0, frame_data},   32'h2AAAAAAA);
    send(DCT_TAKEN, 15);
    chk("t3_full_cnt", {28'd0, dct_count}, 32'd15);
    chk("t3_no_ovf",   {31'd0, overflow},  32'd0);
    chk("t3_f1_stable", {2'd0, frame_data}, 32'h2AAAAAAA);
    send(DCT_RESYNC, 10);
    chk("t3_ovf",      {31'd0, overflow},   32'd1);
    chk("t3_drops",    {24'd0, drop_count}, 32'd10);
    chk("t3_buf_kept", {2'd0, dct_buffer},  32'h15555555);
    chk("t3_f1_count", {28'd0, frame_count}, 32'd15);
    frame_ready = 1'b1; tick();
    chk("t3_f2_valid", {31'd0, frame_valid}, 32'd1);
    chk("t3_f2_data",  {2'd0, frame_data},   32'h15555555);
    chk("t3_f2_cnt0",  {28'd0, dct_count},   32'd0);
    tick();
    chk("t3_drained",  {31'd0, frame_valid}, 32'd0);

    // empty flush is a no-op; code+flush together makes a 1-code frame
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t4_empty_flush", {31'd0, frame_valid}, 32'd0);
    code = DCT_RESYNC; code_valid = 1'b1; flush = 1'b1; tick();
    code_valid = 1'b0; flush = 1'b0;
    chk("t4_valid", {31'd0, frame_valid}, 32'd1);
    chk("t4_count", {28'd0, frame_count}, 32'd1);
    chk("t4_data",  {2'd0, frame_data},   32'd3);
    tick();

    // 15th code in the same cycle the prior frame drains
    frame_ready = 1'b0;
    code = DCT_TAKEN; code_valid = 1'b1; flush = 1'b1; tick(); flush = 1'b0; code_valid = 1'b0;
    send(DCT_RESYNC, 14);
    chk("t5_cnt14", {28'd0, dct_count}, 32'd14);
    chk("t5_hold",  {2'd0, frame_data}, 32'd1);
    frame_ready = 1'b1;
    send(DCT_RESYNC, 1);
    chk("t5_valid", {31'd0, frame_valid}, 32'd1);
    chk("t5_data",  {2'd0, frame_data},   32'h3FFFFFFF);
    chk("t5_count", {28'd0, frame_count}, 32'd15);
    chk("t5_drops", {24'd0, drop_count},  32'd10);
    chk("t5_cnt0",  {28'd0, dct_count},   32'd0);
    tick();

    // async reset mid-frame
    frame_ready = 1'b0;
    code = DCT_TAKEN; code_valid = 1'b1; flush = 1'b1; tick(); flush = 1'b0; code_valid = 1'b0;
    send(DCT_NOT_TAKEN, 7);
    chk("t6_cnt7", {28'd0, dct_count}, 32'd7);
    reset_n = 1'b0;
    #1;
    chk("t6_valid",  {31'd0, frame_valid}, 32'd0);
    chk("t6_data",   {2'd0, frame_data},   32'd0);
    chk("t6_count",  {28'd0, frame_count}, 32'd0);
    chk("t6_dctcnt", {28'd0, dct_count},   32'd0);
    chk("t6_dctbuf", {2'd0, dct_buffer},   32'd0);
    chk("t6_ovf",    {31'd0, overflow},    32'd0);
    chk("t6_drops",  {24'd0, drop_count},  32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick(); tick();

    // test_ending: every code is its own frame
    test_ending = 1'b1; frame_ready = 1'b1;
    send(DCT_NOT_TAKEN, 1);
    chk("t7_a_valid", {31'd0, frame_valid}, 32'd1);
    chk("t7_a_count", {28'd0, frame_count}, 32'd1);
    chk("t7_a_data",  {2'd0, frame_data},   32'd2);
    send(DCT_TAKEN, 1);
    chk("t7_b_valid", {31'd0, frame_valid}, 32'd1);
    chk("t7_b_data",  {2'd0, frame_data},   32'd1);
    chk("t7_b_cnt0",  {28'd0, dct_count},   32'd0);
    tick();
    chk("t7_idle",    {31'd0, frame_valid}, 32'd0);
    test_ending = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
